// File: rtl/dma_engine.sv
// dma_engine: 1024-bit block DMA responder over a 32-bit memory port; DMA_TIMEOUT_EN enables a per-beat ack timeout
module dma_engine #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          dma_rx_start,
    input  logic          dma_tx_start,
    input  logic [31:0]   dma_rx_address,
    input  logic [31:0]   dma_tx_address,
    input  logic [1023:0] dma_tx_data,
    output logic [1023:0] dma_rx_data,
    output logic          dma_done,
    output logic          dma_idle,
    output logic          dma_error,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    input  logic          mem_err
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state, state_d;
    logic [4:0]    beat, beat_d;
    logic [1023:0] blk, blk_d;
    logic [1023:0] rx_data_d;
    logic          done_d, idle_d, err_d, req_d, we_d;
    logic [31:0]   addr_d, wdata_d;

`ifdef DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt, tcnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d   = state;
        beat_d    = beat;
        blk_d     = blk;
        rx_data_d = dma_rx_data;
        done_d    = 1'b0;
        idle_d    = dma_idle;
        err_d     = dma_error;
        req_d     = mem_req;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
`ifdef DMA_TIMEOUT_EN
        tcnt_d    = '0;
`endif
        case (state)
            IDLE: begin
                if (dma_rx_start || dma_tx_start) begin
                    beat_d  = '0;
                    idle_d  = 1'b0;
                    we_d    = !dma_rx_start;
                    addr_d  = dma_rx_start ? dma_rx_address : dma_tx_address;
                    wdata_d = dma_rx_start ? 32'h0 : dma_tx_data[31:0];
                    blk_d   = dma_rx_start ? blk : dma_tx_data;
                    err_d   = addr_d[1:0] != 2'b00;
                    req_d   = addr_d[1:0] == 2'b00;
                    state_d = addr_d[1:0] != 2'b00 ? DONE : (dma_rx_start ? READ : WRITE);
                end
            end
            READ, WRITE: begin
                if (mem_req && mem_ack) begin
                    req_d = 1'b0;
                    if (mem_err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        if (state == READ)
                            blk_d[32*beat +: 32] = mem_rdata;
                        if (beat == 5'd31) begin
                            state_d = DONE;
                        end else begin
                            beat_d  = beat + 5'd1;
                            addr_d  = mem_addr + 32'd4;
                            wdata_d = blk[32*beat_d +: 32];
                        end
                    end
                end else if (!mem_req) begin
                    req_d = 1'b1;
`ifdef DMA_TIMEOUT_EN
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                idle_d    = 1'b1;
                rx_data_d = (!mem_we && !dma_error) ? blk : dma_rx_data;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            beat        <= '0;
            blk         <= '0;
            dma_rx_data <= '0;
            dma_done    <= 1'b0;
            dma_idle    <= 1'b1;
            dma_error   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
`ifdef DMA_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            state       <= state_d;
            beat        <= beat_d;
            blk         <= blk_d;
            dma_rx_data <= rx_data_d;
            dma_done    <= done_d;
            dma_idle    <= idle_d;
            dma_error   <= err_d;
            mem_req     <= req_d;
            mem_we      <= we_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
`ifdef DMA_TIMEOUT_EN
            tcnt        <= tcnt_d;
`endif
        end
    end
endmodule
